fifo_sync_mw_1r: RTL

//   Synchronous FIFO with WR_PORTS parallel write ports and one show-ahead read port.

---
 rtl/fifo_sync_mw_1r.sv | 96 +++++++++
 1 files changed

// File: rtl/fifo_sync_mw_1r.sv
// Synchronous FIFO with WR_PORTS packed write ports and one show-ahead read port.
// Optional sticky overflow/underflow flags are built when FIFO_MW_ERR_EN is defined.
module fifo_sync_mw_1r #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 8,
   parameter int WR_PORTS     = 4,
   parameter int AFULL_THRESH = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WR_PORTS-1:0]          wr_en,
   input  logic [WR_PORTS*WIDTH-1:0]    wr_data,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_MW_ERR_EN
   ,
   output logic                         overflow,
   output logic                         underflow
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr_nxt;
   logic [PW-1:0]       rd_ptr_nxt;
   logic [PW-1:0]       addr [WR_PORTS];
   logic [WR_PORTS-1:0] wr_acc;
   logic                rd_acc;
   logic [CW-1:0]       n_wr;
   int                  n_acc;

   // Pointer advance wraps by comparison so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign empty       = (count == '0);
   assign full        = (int'(count) > DEPTH - WR_PORTS);
   assign almost_full = (int'(count) >= AFULL_THRESH);
   assign rd_data     = mem[rd_ptr];

   assign wr_acc = wr_en & {WR_PORTS{~full}};
   assign rd_acc = rd_en & ~empty;

   // Accepted ports land on consecutive slots in ascending port order, no gaps.
   always_comb begin
      n_acc = 0;
      for (int p = 0; p < WR_PORTS; p++) begin
         addr[p] = adv(wr_ptr, n_acc);
         if (wr_acc[p]) n_acc = n_acc + 1;
      end
      n_wr       = CW'(n_acc);
      wr_ptr_nxt = adv(wr_ptr, n_acc);
      rd_ptr_nxt = rd_acc ? adv(rd_ptr, 1) : rd_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_acc[p]) mem[addr[p]] <= wr_data[p*WIDTH +: WIDTH];
         end
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         count  <= count + n_wr - {{(CW-1){1'b0}}, rd_acc};
      end
   end

`ifdef FIFO_MW_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow | ((|wr_en) & full);
         underflow <= underflow | (rd_en & empty);
      end
   end
`endif

endmodule
